// File: rtl/blft_pixel_feeder.sv
// Raster-order pixel streamer: reads an image SRAM, buffers through a 2-entry FIFO.
// Optional FEEDER_CHECKSUM_EN adds a 16-bit frame_sum of all transferred pixels.
module blft_pixel_feeder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              out_ready,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              in_valid,
  output logic [ADDR_W-1:0] in_addr,
  output logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              done
`ifdef FEEDER_CHECKSUM_EN
  ,
  output logic [15:0]       frame_sum
`endif
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LAST = CW'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [1:0]        occ_q, occ_d;
  logic              infl_q, infl_d;
  logic [DATA_W-1:0] fifo0_q, fifo0_d;
  logic [DATA_W-1:0] fifo1_q, fifo1_d;
  logic [DATA_W-1:0] head;
  logic              xfer;
  logic              push;
  logic              pop;

  always_comb begin
    in_valid = (occ_q != 2'd0) || infl_q;
    // Empty FIFO: the read returning this cycle is presented directly.
    head     = (occ_q != 2'd0) ? fifo0_q : mem_rdata;
    xfer     = in_valid && out_ready;
    in_addr  = in_valid ? tx_cnt_q[ADDR_W-1:0] : '0;
    in_data  = in_valid ? head : '0;
    mem_rd   = (state_q == RUN) && ((occ_q + 2'(infl_q)) < 2'd2);
    mem_addr = mem_rd ? rd_cnt_q[ADDR_W-1:0] : '0;
    busy     = (state_q == RUN) || (state_q == DRAIN);
    done     = (state_q == DONE);
    pop      = xfer && (occ_q != 2'd0);
    push     = infl_q && !(xfer && (occ_q == 2'd0));
  end

  always_comb begin
    fifo0_d  = fifo0_q;
    fifo1_d  = fifo1_q;
    if (pop) fifo0_d = fifo1_q;
    if (push) begin
      if ((occ_q - 2'(pop)) == 2'd0) fifo0_d = mem_rdata;
      else fifo1_d = mem_rdata;
    end
    occ_d    = occ_q + 2'(push) - 2'(pop);
    infl_d   = mem_rd;
    rd_cnt_d = rd_cnt_q + CW'(mem_rd);
    tx_cnt_d = tx_cnt_q + CW'(xfer);
    state_d  = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          rd_cnt_d = '0;
          tx_cnt_d = '0;
        end
      end
      RUN:     if (mem_rd && rd_cnt_q == LAST) state_d = DRAIN;
      DRAIN:   if (xfer && tx_cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rd_cnt_q <= '0;
      tx_cnt_q <= '0;
      occ_q    <= '0;
      infl_q   <= 1'b0;
      fifo0_q  <= '0;
      fifo1_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      fifo0_q  <= fifo0_d;
      fifo1_q  <= fifo1_d;
    end
  end

`ifdef FEEDER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == IDLE && start) sum_d = '0;
    else if (xfer) sum_d = sum_q + 16'(in_data);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sum_q <= '0;
    else sum_q <= sum_d;
  end

  assign frame_sum = sum_q;
`endif

endmodule

// File: tb/tb_blft_pixel_feeder.sv
// Bench for blft_pixel_feeder: 4x4 frames under varied backpressure plus a 256x256 run.
// Checksum checks compile in with FEEDER_CHECKSUM_EN.
module tb_blft_pixel_feeder;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int N  = 16;

  logic clk = 0, rst_n = 0, start = 0, out_ready = 0;
  logic mem_rd, in_valid, busy, done;
  logic [AW-1:0] mem_addr, in_addr;
  logic [DW-1:0] mem_rdata, in_data;
  logic [15:0] frame_sum;
  logic b_start = 0, b_ready = 1;
  logic b_mem_rd, b_in_valid, b_busy, b_done;
  logic [AW-1:0] b_mem_addr, b_in_addr;
  logic [DW-1:0] b_mem_rdata, b_in_data;
  logic [15:0] b_frame_sum;

  blft_pixel_feeder #(.ADDR_W(AW), .DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst(rst_n), .start(start), .out_ready(out_ready),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .busy(busy), .done(done)
`ifdef FEEDER_CHECKSUM_EN
    , .frame_sum(frame_sum)
`endif
  );

  blft_pixel_feeder #(.ADDR_W(AW), .DATA_W(DW), .IMG_W(256), .IMG_H(256)) dut_big (
    .clk(clk), .rst(rst_n), .start(b_start), .out_ready(b_ready),
    .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata),
    .in_valid(b_in_valid), .in_addr(b_in_addr), .in_data(b_in_data),
    .busy(b_busy), .done(b_done)
`ifdef FEEDER_CHECKSUM_EN
    , .frame_sum(b_frame_sum)
`endif
  );

`ifndef FEEDER_CHECKSUM_EN
  assign frame_sum = '0;
  assign b_frame_sum = '0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] img [N];
  always @(posedge clk) if (mem_rd) mem_rdata <= img[mem_addr[3:0]];

  function automatic logic [7:0] bpix(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  always @(posedge clk) if (b_mem_rd) b_mem_rdata <= bpix(b_mem_addr);

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Small-frame monitor: expected stream is pixel i at address i, in order.
  logic mon_clr = 0;
  int xfers, issued, done_cnt, done_cyc, first_v;
  bit st_prev;
  logic [AW-1:0] st_addr, last_addr;
  logic [DW-1:0] st_data;
  logic [15:0] sum_done;

  always @(negedge clk) begin
    if (mon_clr) begin
      xfers = 0; issued = 0; done_cnt = 0; done_cyc = -1;
      first_v = -1; st_prev = 0; last_addr = '1; sum_done = '0;
    end else if (rst_n) begin
      if (st_prev)
        chk("stall_hold", {in_valid, in_addr, in_data}, {1'b1, st_addr, st_data});
      if (in_valid) begin
        if (first_v < 0) first_v = cyc;
        chk("busy_while_valid", busy, 1);
      end else if (busy) begin
        chk("idle_bus_zero", {in_addr, in_data}, 0);
      end
      if (mem_rd) begin
        chk("rd_credit", (issued - xfers) < 2, 1);
        chk("rd_addr", mem_addr, issued);
        issued++;
      end
      if (in_valid && out_ready) begin
        if (xfers < N) begin
          chk("xfer_addr", in_addr, xfers);
          chk("xfer_data", in_data, img[xfers]);
        end else begin
          chk("extra_xfer", xfers, N - 1);
        end
        xfers++;
        last_addr = in_addr;
      end
      st_prev = in_valid && !out_ready;
      st_addr = in_addr;
      st_data = in_data;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        sum_done = frame_sum;
      end
    end
  end

  int b_cnt = 0, b_done_cnt = 0;
  logic [15:0] b_last = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_in_valid) begin
        if (b_cnt < 65536) begin
          chk("big_addr", b_in_addr, b_cnt[15:0]);
          chk("big_data", b_in_data, bpix(b_cnt[15:0]));
        end else begin
          chk("big_extra", b_cnt, 65535);
        end
        b_cnt++;
        b_last = b_in_addr;
      end
      if (b_done) b_done_cnt++;
    end
  end

  typedef struct {
    int rdy_mode;
    bit rnd_img;
    int extra;
    int exp_xfers;
    int exp_first;
    int exp_done;
  } vec_t;

  function automatic logic rdy(input int mode, input int t);
    case (mode)
      0: return 1'b1;
      1: return (t % 2) == 0;
      2: return 1'($urandom % 2);
      default: return $urandom_range(0, 3) == 0;
    endcase
  endfunction

  task automatic run_frame(input vec_t v);
    int k;
    logic [15:0] exp_sum;
    exp_sum = 0;
    for (int i = 0; i < N; i++) begin
      img[i] = v.rnd_img ? 8'($urandom) : 8'(i + 16);
      exp_sum += 16'(img[i]);
    end
    @(posedge clk); #1 mon_clr = 1;
    @(posedge clk); #1 mon_clr = 0;
    out_ready = rdy(v.rdy_mode, 0);
    start = 1;
    @(posedge clk); #1 start = 0;
    k = cyc;
    @(negedge clk);
    chk("start_busy_rd", {busy, mem_rd, in_valid}, 3'b110);
`ifdef FEEDER_CHECKSUM_EN
    chk("sum_cleared", frame_sum, 0);
`endif
    for (int t = 1; t < 400 && done_cnt == 0; t++) begin
      @(posedge clk); #1;
      out_ready = rdy(v.rdy_mode, t);
      start = (v.extra == 1 && t == 5) || (v.extra == 2 && cyc == k + v.exp_done);
    end
    start = 0;
    chk("done_seen", done_cnt > 0, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_idle", {busy, mem_rd, in_valid}, 0);
`ifdef FEEDER_CHECKSUM_EN
      chk("sum_stable", frame_sum, sum_done);
`endif
    end
    chk("done_once", done_cnt, 1);
    chk("xfer_count", xfers, v.exp_xfers);
    chk("last_addr", last_addr, v.exp_xfers - 1);
    chk("first_valid", first_v - k, v.exp_first);
    if (v.exp_done >= 0) chk("done_cycle", done_cyc - k, v.exp_done);
`ifdef FEEDER_CHECKSUM_EN
    chk("frame_sum", sum_done, exp_sum);
`else
    if (exp_sum == 16'hFFFF) $display("note: all-ones sum");
`endif
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{0, 0, 0, N, 1, 17};
    vecs[1] = '{1, 0, 0, N, 1, -1};
    vecs[2] = '{2, 1, 0, N, 1, -1};
    vecs[3] = '{3, 1, 1, N, 1, -1};
    vecs[4] = '{0, 1, 2, N, 1, 17};
    vecs[5] = '{1, 1, 1, N, 1, -1};

    repeat (3) @(negedge clk);
    chk("reset_outs", {mem_rd, mem_addr, in_valid, in_addr, in_data, busy, done}, 0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_outs", {mem_rd, mem_addr, in_valid, in_addr, in_data, busy, done}, 0);
      chk("idle_big", {b_mem_rd, b_in_valid, b_busy, b_done}, 0);
    end

    foreach (vecs[i]) run_frame(vecs[i]);

    for (int i = 0; i < N; i++) img[i] = 8'(i + 16);
    @(posedge clk); #1 mon_clr = 1;
    @(posedge clk); #1 mon_clr = 0;
    out_ready = 1;
    start = 1;
    @(posedge clk); #1 start = 0;
    for (int t = 0; t < 50 && xfers < 7; t++) @(negedge clk);
    chk("reach_xfer7", xfers, 7);
    #2 rst_n = 0;
    #1;
    chk("async_rst_outs", {mem_rd, mem_addr, in_valid, in_addr, in_data, busy, done}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(negedge clk);
    chk("no_done_after_abort", {done_cnt, busy}, 0);
    run_frame(vecs[0]);

    @(posedge clk); #1 b_start = 1;
    @(posedge clk); #1 b_start = 0;
    for (int t = 0; t < 66000 && b_done_cnt == 0; t++) @(negedge clk);
    chk("big_done_seen", b_done_cnt > 0, 1);
    repeat (5) @(negedge clk);
    chk("big_count", b_cnt, 65536);
    chk("big_last", b_last, 16'hFFFF);
    chk("big_done_once", b_done_cnt, 1);
    chk("big_quiet", {b_in_valid, b_mem_rd, b_busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/blft_pixel_feeder.md
Name: blft_pixel_feeder

Overview:
- Input-side driver for the bilateral filter core. Drives the filter's pixel stream: in_valid, in_addr and in_data.
- Fetches an IMG_W x IMG_H 8-bit image from a synchronous single-port image SRAM. Emits the pixels in raster order, one per clock.
- Supports downstream backpressure and signals end of frame.
- Replaces the behavioural pattern source in synthesizable frame-level tests and on-chip self-test.

Parameters:
- ADDR_W, 16: pixel address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- DATA_W, 8: pixel width.
- IMG_W, 256: image width in pixels.
- IMG_H, 256: image height in pixels.

Ports:
- clk, input, 1: single clock; all state on rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle request to stream one frame; ignored unless state is IDLE.
- out_ready, input, 1: downstream can accept a pixel; tie high for the filter core.
- mem_rd, output, 1: SRAM read enable.
- mem_addr, output, ADDR_W: SRAM read address.
- mem_rdata, input, DATA_W: SRAM read data, valid exactly 1 cycle after mem_rd.
- in_valid, output, 1: pixel valid toward the filter.
- in_addr, output, ADDR_W: raster address of the current pixel.
- in_data, output, DATA_W: pixel value.
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: one-cycle pulse after the final pixel transfer.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all counters=0, FIFO empty.
  - Outputs: mem_rd=0, mem_addr=0, in_valid=0, in_addr=0, in_data=0, busy=0, done=0.
  - Reset mid-frame aborts the frame immediately; no done pulse.
- State machine: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE -> RUN on start=1.
  - RUN -> DRAIN when the read counter issues address IMG_W*IMG_H-1.
  - DRAIN -> DONE when the final pixel transfers.
  - DONE lasts 1 cycle (done=1), then returns to IDLE.
- Transfer rule: a transfer occurs when in_valid=1 and out_ready=1.
  - in_valid, in_addr and in_data must hold stable while in_valid=1 and out_ready=0.
  - in_addr and in_data are driven 0 whenever in_valid=0.
- Buffering: 2-entry output FIFO.
  - mem_rd=1 only when (FIFO occupancy + reads in flight) < 2.
  - This guarantees no overflow under any out_ready pattern.
  - mem_rdata is written into the FIFO on the cycle after mem_rd.
- Address generation:
  - Read counter rd_cnt starts at 0 and increments on each mem_rd; mem_addr = rd_cnt[ADDR_W-1:0].
  - Output counter tx_cnt increments on each transfer; in_addr equals the address of the pixel being presented.
  - Both counters are ADDR_W+1 bits wide so that IMG_W*IMG_H = 2^ADDR_W (65536) terminates correctly.
  - Neither counter wraps within a frame.
- Latency and throughput:
  - start sampled at edge k -> busy=1 and first mem_rd during cycle k+1 -> in_valid=1 during cycle k+2.
  - With out_ready held high: 1 pixel/clk, no bubbles.
  - Final transfer at cycle k+1+IMG_W*IMG_H; done=1 in the following cycle.
- Simultaneous events:
  - start while not IDLE: ignored.
  - start in the same cycle as done: ignored; a new start is accepted only from IDLE.
  - out_ready toggling every cycle: no pixel dropped or duplicated.
- The image SRAM is read-only to this block; contents are never modified.

Optional Feature:
- Macro FEEDER_CHECKSUM_EN.
- When defined:
  - Adds output port frame_sum, width 16, after done.
  - Holds the modulo-2^16 sum of all transferred in_data in the current or last frame.
  - Cleared to 0 on reset and when start is accepted; updated on every transfer.
  - Stable from the done pulse until the next accepted start.
- When undefined: the port and accumulator do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle, no start -> all outputs 0 for 100 cycles; mem_rd never asserted.
- IMG_W=4, IMG_H=4, SRAM[i]=i+16, out_ready=1, start pulse at edge k:
  - in_valid high during cycles k+2..k+17.
  - in_addr=0..15 and in_data=16..31 in order.
  - done=1 during cycle k+18 only.
- Same image, out_ready = 1,0,1,0,...:
  - exactly 16 transfers, addresses 0..15 strictly in order.
  - outputs stable during every stall.
  - mem_rd never issued when (occupancy + reads in flight) = 2.
- Default parameters (256x256) with out_ready=1:
  - 65536 transfers; last in_addr=16'hFFFF.
  - done pulses exactly once; no counter wrap to address 0 after the last pixel.
- rst driven low at transfer 7 of the 4x4 frame:
  - outputs 0 immediately (asynchronous), no done pulse.
  - after release, a new start replays from in_addr=0.
- FEEDER_CHECKSUM_EN defined, 4x4 frame with SRAM[i]=i+16:
  - frame_sum=16'd376 at done.
  - a second start clears frame_sum to 0 on the next cycle.
